// File: rtl/cva5_types.sv
// Shared types for the fetch -> decode instruction queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cva5_types;

  // Core-default widths for the instruction ID and the fetch exception code.
  localparam int FQ_ID_WIDTH    = 3;
  localparam int FQ_ECODE_WIDTH = 5;

  // One queued fetch: PC, instruction word, ID and fetch metadata.
  typedef struct packed {
    logic [31:0]               pc;
    logic [31:0]               instruction;
    logic [FQ_ID_WIDTH-1:0]    id;
    logic                      ok;
    logic [FQ_ECODE_WIDTH-1:0] error_code;
  } fetch_queue_entry_t;

  // Payload width of one entry for arbitrary ID / exception-code widths.
  function automatic int fq_entry_width(input int id_w, input int ecode_w);
    return 32 + 32 + id_w + 1 + ecode_w;
  endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// Simple dual-port entry memory: one synchronous write port, one asynchronous read port.
// Latency: a write lands at the clock edge; the read port reflects it from the next cycle.
// Backpressure: none; the caller owns all flow control. Contents have no reset.
module fetch_queue_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 73
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry only when a push is accepted.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read of the entry at the read address.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// Elastic FIFO of fetched instructions feeding decode; flush drops every entry.
// Latency: an entry pushed in cycle N is at the head in cycle N+1 (no bypass).
// Backpressure: fetch_ready = not full from registered state only; a pop does not free a slot the same cycle.
module fetch_decode_queue
  import cva5_types::*;
#(
  parameter int DEPTH       = 4,
  parameter int ID_WIDTH    = FQ_ID_WIDTH,
  parameter int ECODE_WIDTH = FQ_ECODE_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [31:0]                fetch_pc,
  input  logic [31:0]                fetch_instruction,
  input  logic [ID_WIDTH-1:0]        fetch_id,
  input  logic                       fetch_ok,
  input  logic [ECODE_WIDTH-1:0]     fetch_error_code,
  output logic                       decode_valid,
  output logic [31:0]                decode_pc,
  output logic [31:0]                decode_instruction,
  output logic [ID_WIDTH-1:0]        decode_id,
  output logic                       decode_ok,
  output logic [ECODE_WIDTH-1:0]     decode_error_code,
  input  logic                       decode_advance,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = fq_entry_width(ID_WIDTH, ECODE_WIDTH);

  // Same layout as fetch_queue_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            instruction;
    logic [ID_WIDTH-1:0]    id;
    logic                   ok;
    logic [ECODE_WIDTH-1:0] error_code;
  } entry_t;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  entry_t        wr_entry;
  entry_t        rd_entry;

  assign fetch_ready  = (count_q != CW'(DEPTH));
  assign decode_valid = (count_q != '0);
  assign occupancy    = count_q;

  // Handshakes; flush suppresses both sides in its cycle.
  assign push = fetch_valid & fetch_ready & ~flush;
  assign pop  = decode_advance & decode_valid & ~flush;

  // Pack the incoming fetch into one storage word.
  always_comb begin
    wr_entry             = '0;
    wr_entry.pc          = fetch_pc;
    wr_entry.instruction = fetch_instruction;
    wr_entry.id          = fetch_id;
    wr_entry.ok          = fetch_ok;
    wr_entry.error_code  = fetch_error_code;
  end

  fetch_queue_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_storage (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign decode_pc          = rd_entry.pc;
  assign decode_instruction = rd_entry.instruction;
  assign decode_id          = rd_entry.id;
  assign decode_ok          = rd_entry.ok;
  assign decode_error_code  = rd_entry.error_code;

  // Next-state for pointers and count; flush empties the queue and rewinds both pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with synchronous reset taking priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue using a scoreboard queue of expected entries.
// Latency: checks head visibility one cycle after push.
// Backpressure: exercises full, simultaneous push/pop, flush and reset.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int IDW   = 3;
  localparam int EW    = 5;

  typedef struct packed {
    logic [31:0]    pc;
    logic [31:0]    instr;
    logic [IDW-1:0] id;
    logic           ok;
    logic [EW-1:0]  ec;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           fetch_valid = 1'b0;
  logic           fetch_ready;
  logic [31:0]    fetch_pc = '0;
  logic [31:0]    fetch_instruction = '0;
  logic [IDW-1:0] fetch_id = '0;
  logic           fetch_ok = 1'b1;
  logic [EW-1:0]  fetch_error_code = '0;
  logic           decode_valid;
  logic [31:0]    decode_pc;
  logic [31:0]    decode_instruction;
  logic [IDW-1:0] decode_id;
  logic           decode_ok;
  logic [EW-1:0]  decode_error_code;
  logic           decode_advance = 1'b0;
  logic [2:0]     occupancy;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  fetch_decode_queue #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .ECODE_WIDTH(EW)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .fetch_valid        (fetch_valid),
    .fetch_ready        (fetch_ready),
    .fetch_pc           (fetch_pc),
    .fetch_instruction  (fetch_instruction),
    .fetch_id           (fetch_id),
    .fetch_ok           (fetch_ok),
    .fetch_error_code   (fetch_error_code),
    .decode_valid       (decode_valid),
    .decode_pc          (decode_pc),
    .decode_instruction (decode_instruction),
    .decode_id          (decode_id),
    .decode_ok          (decode_ok),
    .decode_error_code  (decode_error_code),
    .decode_advance     (decode_advance),
    .occupancy          (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  // Drive one cycle of stimulus and update the scoreboard from the bench's own model.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [IDW-1:0] id,
                       input logic ok, input logic [EW-1:0] ec, input logic adv, input logic fl);
    exp_t e;
    bit   acc;
    bit   pp;
    fetch_valid       = v;
    fetch_pc          = pc;
    fetch_instruction = instr_of(pc);
    fetch_id          = id;
    fetch_ok          = ok;
    fetch_error_code  = ec;
    decode_advance    = adv;
    flush             = fl;
    acc = v && (sb.size() < DEPTH) && !fl && !rst;
    pp  = adv && (sb.size() > 0) && !fl && !rst;
    e = '{pc: pc, instr: instr_of(pc), id: id, ok: ok, ec: ec};
    @(posedge clk);
    #1;
    if (rst || fl) begin
      sb.delete();
    end else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back(e);
    end
    fetch_valid    = 1'b0;
    decode_advance = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [IDW-1:0] id);
    drive(1'b1, pc, id, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, '0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++;
    if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ act=%0d exp=0", occupancy); end
    checks++;
    if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready act=%b exp=1", fetch_ready); end
    checks++;
    if (decode_valid !== 1'b0) begin errors++; $display("FAIL reset_valid act=%b exp=0", decode_valid); end
  endtask

  // Consecutive pushes, head visible one cycle after the first, then drain in order.
  task automatic test_latency();
    push(32'h100, 3'd1);
    checks++;
    if (decode_valid !== 1'b1 || decode_pc !== 32'h100)
      begin errors++; $display("FAIL lat_first valid=%b pc=%h exp valid=1 pc=00000100", decode_valid, decode_pc); end
    push(32'h104, 3'd2);
    push(32'h108, 3'd3);
    checks++;
    if (occupancy !== 3'd3) begin errors++; $display("FAIL lat_occ act=%0d exp=3", occupancy); end
    checks++;
    if (decode_pc !== 32'h100) begin errors++; $display("FAIL lat_head act=%h exp=00000100", decode_pc); end
    for (int i = 0; i < 8 && sb.size() > 0; i++) begin
      checks++;
      if (decode_valid !== 1'b1 || decode_pc !== sb[0].pc || decode_instruction !== sb[0].instr || decode_id !== sb[0].id)
        begin errors++; $display("FAIL lat_drain pc=%h id=%0d exp pc=%h id=%0d", decode_pc, decode_id, sb[0].pc, sb[0].id); end
      drive(1'b0, '0, '0, 1'b1, '0, 1'b1, 1'b0);
    end
    checks++;
    if (decode_valid !== 1'b0) begin errors++; $display("FAIL lat_empty valid=%b exp=0", decode_valid); end
  endtask

  // Fill to DEPTH, reject a fifth push, and free a slot with one pop.
  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) push(32'h400 + 32'(i * 4), 3'(i));
    checks++;
    if (fetch_ready !== 1'b0 || occupancy !== 3'd4)
      begin errors++; $display("FAIL full_ready ready=%b occ=%0d exp ready=0 occ=4", fetch_ready, occupancy); end
    push(32'h500, 3'd7);
    checks++;
    if (occupancy !== 3'd4) begin errors++; $display("FAIL full_reject occ=%0d exp=4", occupancy); end
    drive(1'b0, '0, '0, 1'b1, '0, 1'b1, 1'b0);
    checks++;
    if (fetch_ready !== 1'b1 || occupancy !== 3'd3)
      begin errors++; $display("FAIL full_pop ready=%b occ=%0d exp ready=1 occ=3", fetch_ready, occupancy); end
  endtask

  // While full, a simultaneous push and pop only pops.
  task automatic test_full_push_pop();
    push(32'h410, 3'd4);
    checks++;
    if (occupancy !== 3'd4) begin errors++; $display("FAIL fpp_refill occ=%0d exp=4", occupancy); end
    drive(1'b1, 32'h600, 3'd6, 1'b1, '0, 1'b1, 1'b0);
    checks++;
    if (occupancy !== 3'd3) begin errors++; $display("FAIL fpp_occ occ=%0d exp=3", occupancy); end
    for (int i = 0; i < 8 && sb.size() > 0; i++) begin
      checks++;
      if (decode_valid !== 1'b1 || decode_pc !== sb[0].pc || decode_id !== sb[0].id)
        begin errors++; $display("FAIL fpp_order pc=%h id=%0d exp pc=%h id=%0d", decode_pc, decode_id, sb[0].pc, sb[0].id); end
      drive(1'b0, '0, '0, 1'b1, '0, 1'b1, 1'b0);
    end
    checks++;
    if (decode_valid !== 1'b0 || occupancy !== 3'd0)
      begin errors++; $display("FAIL fpp_empty valid=%b occ=%0d exp valid=0 occ=0", decode_valid, occupancy); end
  endtask

  // Steady streaming across pointer wrap with ids wrapping 0..7.
  task automatic test_wrap();
    push(32'h800, 3'd6);
    push(32'h804, 3'd7);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (decode_pc !== sb[0].pc || decode_id !== sb[0].id || decode_instruction !== sb[0].instr)
        begin errors++; $display("FAIL wrap_order i=%0d pc=%h id=%0d exp pc=%h id=%0d", i, decode_pc, decode_id, sb[0].pc, sb[0].id); end
      drive(1'b1, 32'h900 + 32'(i * 4), 3'(i), 1'b1, '0, 1'b1, 1'b0);
      checks++;
      if (occupancy !== 3'd2) begin errors++; $display("FAIL wrap_occ i=%0d occ=%0d exp=2", i, occupancy); end
    end
  endtask

  // Flush with push and pop asserted drops everything, including the pushed entry.
  task automatic test_flush();
    push(32'hA00, 3'd1);
    checks++;
    if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre occ=%0d exp=3", occupancy); end
    drive(1'b1, 32'hF00, 3'd5, 1'b1, '0, 1'b1, 1'b1);
    checks++;
    if (occupancy !== 3'd0 || decode_valid !== 1'b0 || fetch_ready !== 1'b1)
      begin errors++; $display("FAIL flush_state occ=%0d valid=%b ready=%b exp occ=0 valid=0 ready=1", occupancy, decode_valid, fetch_ready); end
    push(32'h200, 3'd2);
    checks++;
    if (decode_valid !== 1'b1 || decode_pc !== sb[0].pc)
      begin errors++; $display("FAIL flush_after pc=%h exp=%h", decode_pc, sb[0].pc); end
    drive(1'b0, '0, '0, 1'b1, '0, 1'b1, 1'b0);
    checks++;
    if (decode_valid !== 1'b0) begin errors++; $display("FAIL flush_drain valid=%b exp=0", decode_valid); end
  endtask

  // Error metadata passes through; reset mid-stream empties the queue.
  task automatic test_error_and_reset();
    drive(1'b1, 32'h300, 3'd3, 1'b0, 5'd1, 1'b0, 1'b0);
    checks++;
    if (decode_ok !== 1'b0 || decode_error_code !== 5'd1 || decode_pc !== 32'h300)
      begin errors++; $display("FAIL err_meta ok=%b ec=%0d pc=%h exp ok=0 ec=1 pc=00000300", decode_ok, decode_error_code, decode_pc); end
    push(32'h304, 3'd4);
    rst = 1'b1;
    drive(1'b1, 32'h308, 3'd5, 1'b1, '0, 1'b1, 1'b0);
    rst = 1'b0;
    checks++;
    if (occupancy !== 3'd0 || decode_valid !== 1'b0 || fetch_ready !== 1'b1)
      begin errors++; $display("FAIL rst_mid occ=%0d valid=%b ready=%b exp occ=0 valid=0 ready=1", occupancy, decode_valid, fetch_ready); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_full_push_pop();
    test_wrap();
    test_flush();
    test_error_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
